// File: rtl/seg_display_ctrl_pkg.sv
// Shared types, glyph constants and the hex-to-segment encoder for the
// multiplexed seven-segment display controller.
package seg_pkg;

    typedef enum logic {
        DISP_HEX = 1'b0,
        DISP_DEC = 1'b1
    } disp_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low glyphs, bit 0 = segment A ... bit 6 = segment G.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter: one bit per cycle, then a
// single COMMIT cycle during which the result is handed to the display.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [WIDTH-1:0]       bin_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DIGITS-1:0][3:0] bcd_o,
    output logic                   ovf_o
);

    // Enough BCD digits for any WIDTH-bit value, and always at least one
    // more than displayed so overflow is simply "any upper digit nonzero".
    localparam int NB_RAW = (WIDTH + 2) / 3;
    localparam int NB     = (NB_RAW > DIGITS) ? NB_RAW : DIGITS + 1;
    localparam int CW     = $clog2(WIDTH + 1);

    conv_state_t         state_q, state_d;
    logic [NB-1:0][3:0]  bcd_q, bcd_d, bcd_adj;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        for (int k = 0; k < NB; k++)
            bcd_adj[k] = (bcd_q[k] >= 4'd5) ? bcd_q[k] + 4'd3 : bcd_q[k];
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CONV;
                    bin_d   = bin_i;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = COMMIT;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == COMMIT);
    assign bcd_o  = bcd_q[DIGITS-1:0];
    assign ovf_o  = |bcd_q[NB-1:DIGITS];

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment controller: double-buffered hex/decimal digits,
// leading-zero blanking, per-digit decimal points and overflow dashes.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int WIDTH       = 16,
    parameter int REFRESH_DIV = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  value_i,
    input  logic              load_i,
    input  logic              mode_i,
    input  logic              lz_blank_i,
    input  logic [DIGITS-1:0] dp_mask_i,
    output logic              busy_o,
    output logic [6:0]        seg_o,
    output logic              dp_o,
    output logic [DIGITS-1:0] an_o
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;

    logic [PW-1:0]           pre_q, pre_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DIGITS-1:0][3:0]  dig_q, dig_d, conv_bcd;
    logic                    ovf_q, ovf_d, conv_ovf, conv_done;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [DIGITS-1:0]       an_q, an_d;
    logic                    accept, dec_start, hex_ld, blank;
    logic [VW-1:0]           val_ext;
    logic [DIGITS-1:0]       zero_from;
    logic [3:0]              cur;

    assign accept    = load_i & ~busy_o;
    assign dec_start = accept & (disp_mode_t'(mode_i) == DISP_DEC);
    assign hex_ld    = accept & (disp_mode_t'(mode_i) == DISP_HEX);
    assign val_ext   = VW'(value_i);

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (dec_start),
        .bin_i   (value_i),
        .busy_o  (busy_o),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd),
        .ovf_o   (conv_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
            dig_q <= '0;
            ovf_q <= 1'b0;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            dig_q <= dig_d;
            ovf_q <= ovf_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PW'(REFRESH_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        dig_d = dig_q;
        ovf_d = ovf_q;
        if (hex_ld) begin
            for (int i = 0; i < DIGITS; i++)
                dig_d[i] = val_ext[4*i +: 4];
            ovf_d = 1'b0;
        end else if (conv_done) begin
            dig_d = conv_bcd;
            ovf_d = conv_ovf;
        end

        // zero_from[i]: digits i..DIGITS-1 are all zero.
        zero_from = '0;
        for (int i = DIGITS - 1; i >= 0; i--)
            zero_from[i] = (dig_q[i] == 4'd0) &
                           ((i == DIGITS - 1) ? 1'b1 : zero_from[(i + 1) % DIGITS]);

        cur   = dig_q[idx_q];
        blank = lz_blank_i & ~ovf_q & (idx_q != '0) & zero_from[idx_q];
        if (ovf_q)      seg_d = SEG_DASH;
        else if (blank) seg_d = SEG_BLANK;
        else            seg_d = hex_to_seg(cur);
        dp_d = ~dp_mask_i[idx_q];
        an_d = ~(DIGITS'(1) << idx_q);
    end

    assign seg_o = seg_q;
    assign dp_o  = dp_q;
    assign an_o  = an_q;

endmodule
